// File: rtl/uart_tx.sv
// UART transmitter on the x8 bit clock: TDR/TSR double buffer,
// start, LSB-first data, optional parity and 1-2 stop bits.
module uart_tx #(
    parameter int data_bits  = 8,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 bclkx8,
    input  logic                 rst,
    input  logic                 tdr_wr,
    input  logic [data_bits-1:0] din,
    output logic                 txd,
    output logic                 tdre,
    output logic                 busy,
    output logic                 tx_done
);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        STOP
    } state_t;

    localparam logic [3:0] LAST_BIT  = 4'(data_bits - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);
    localparam logic       ODD       = 1'(PARITY_ODD);

    state_t               state, state_n;
    logic [2:0]           ct1, ct1_n;
    logic [3:0]           ct2, ct2_n;
    logic [data_bits-1:0] tdr, tdr_n;
    logic [data_bits-1:0] tsr, tsr_n;
    logic                 par, par_n;
    logic                 tdre_n, txd_n, done_n;
    logic                 last_tick;
    logic                 xfer;

    assign last_tick = (ct1 == 3'd7);

    always_comb begin
        state_n = state;
        ct1_n   = ct1 + 3'd1;
        ct2_n   = ct2;
        tsr_n   = tsr;
        par_n   = par;
        tdr_n   = tdr;
        tdre_n  = tdre;
        xfer    = 1'b0;

        unique case (state)
            IDLE: begin
                ct1_n = 3'd0;
            end
            START: begin
                if (last_tick) state_n = DATA;
            end
            DATA: begin
                if (last_tick) begin
                    tsr_n = tsr >> 1;
                    par_n = par ^ tsr[0];
                    ct2_n = ct2 + 4'd1;
                    if (ct2 == LAST_BIT) begin
                        ct2_n   = 4'd0;
                        state_n = (PARITY_EN != 0) ? PARITY : STOP;
                    end
                end
            end
            PARITY: begin
                if (last_tick) begin
                    ct2_n   = 4'd0;
                    state_n = STOP;
                end
            end
            STOP: begin
                if (last_tick) begin
                    if (ct2 == LAST_STOP) state_n = IDLE;
                    else ct2_n = ct2 + 4'd1;
                end
            end
            default: state_n = IDLE;
        endcase

        // A pending word starts right after the last stop tick: no idle gap.
        if (!tdre && (state == IDLE ||
            (state == STOP && last_tick && ct2 == LAST_STOP))) begin
            xfer = 1'b1;
        end

        if (xfer) begin
            tsr_n   = tdr;
            state_n = START;
            ct1_n   = 3'd0;
            ct2_n   = 4'd0;
            par_n   = 1'b0;
            tdre_n  = 1'b1;
        end else if (tdr_wr && tdre) begin
            tdr_n  = din;
            tdre_n = 1'b0;
        end

        unique case (state_n)
            START:   txd_n = 1'b0;
            DATA:    txd_n = tsr_n[0];
            PARITY:  txd_n = par_n ^ ODD;
            default: txd_n = 1'b1;
        endcase

        done_n = (state_n == STOP) && (ct1_n == 3'd7) &&
                 (ct2_n == LAST_STOP);
    end

    always_ff @(posedge bclkx8) begin
        if (rst) begin
            state   <= IDLE;
            ct1     <= 3'd0;
            ct2     <= 4'd0;
            par     <= 1'b0;
            tdre    <= 1'b1;
            txd     <= 1'b1;
            busy    <= 1'b0;
            tx_done <= 1'b0;
        end else begin
            state   <= state_n;
            ct1     <= ct1_n;
            ct2     <= ct2_n;
            par     <= par_n;
            tdre    <= tdre_n;
            txd     <= txd_n;
            busy    <= (state_n != IDLE);
            tx_done <= done_n;
        end
    end

    always_ff @(posedge bclkx8) begin
        tdr <= tdr_n;
        tsr <= tsr_n;
    end

endmodule
